// File: rtl/fifo_byte_packer.sv
// fifo_byte_packer
//   Read-side consumer of a synchronous byte FIFO. It pops bytes, packs LANES
//   consecutive bytes into one little-endian word and presents that word on a
//   valid/ready master port. A flush request emits a partially filled word
//   with a lane-keep mask and m_last set.
//
// Ports
//   clk      in   single clock, all logic on posedge
//   rst      in   synchronous active-high reset
//   empty    in   FIFO empty flag
//   dataout  in   FIFO read data, valid the cycle after r_en
//   r_en     out  FIFO pop request (combinational)
//   flush    in   single-cycle request to emit any partial word
//   m_valid  out  output word valid
//   m_ready  in   downstream accepts the word when m_valid && m_ready
//   m_data   out  packed word, first byte popped in bits [WIDTH-1:0]
//   m_keep   out  per-lane valid mask, all-ones for full words
//   m_last   out  word was produced by a flush
module fifo_byte_packer #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   empty,
  input  logic [WIDTH-1:0]       dataout,
  output logic                   r_en,
  input  logic                   flush,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH*LANES-1:0] m_data,
  output logic [LANES-1:0]       m_keep,
  output logic                   m_last
);

  localparam int CW = $clog2(LANES + 1);
  localparam logic [CW-1:0] LANES_C = CW'(LANES);
  localparam logic [CW:0]   LANES_X = (CW + 1)'(LANES);

  logic [WIDTH*LANES-1:0] acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          cnt_inc;
  logic                   rd_pend_q;
  logic                   acc_full_q, acc_full_d;
  logic                   flush_req_q, flush_req_d;
  logic                   m_valid_q, m_valid_d;
  logic [WIDTH*LANES-1:0] m_data_q, m_data_d;
  logic [LANES-1:0]       m_keep_q, m_keep_d;
  logic                   m_last_q, m_last_d;
  logic                   out_free;
  logic [CW:0]            fill_lvl;
  logic [WIDTH*LANES-1:0] part_data;
  logic [LANES-1:0]       part_keep;

  assign out_free = !m_valid_q || m_ready;

  // Bytes already captured plus the one in flight; one bit wider so the sum
  // cannot wrap.
  assign fill_lvl = {1'b0, cnt_q} + {{CW{1'b0}}, rd_pend_q};

  assign r_en = !empty && !rst && !flush_req_q && !acc_full_q && (fill_lvl < LANES_X);

  assign cnt_inc = cnt_q + 1'b1;

  // Partial word for a flush: stale bytes above cnt are masked to zero.
  always_comb begin
    part_data = '0;
    part_keep = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(cnt_q)) begin
        part_keep[i]                = 1'b1;
        part_data[i*WIDTH +: WIDTH] = acc_q[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    acc_full_d  = acc_full_q;
    flush_req_d = flush_req_q | flush;
    m_valid_d   = m_valid_q & ~m_ready;
    m_data_d    = m_data_q;
    m_keep_d    = m_keep_q;
    m_last_d    = m_last_q;

    if (rd_pend_q) begin
      acc_d[int'(cnt_q)*WIDTH +: WIDTH] = dataout;
      cnt_d                             = cnt_inc;
    end

    if (rd_pend_q && (cnt_inc == LANES_C)) begin
      // Word completes on this capture; forward it directly when possible.
      if (out_free) begin
        m_valid_d   = 1'b1;
        m_data_d    = acc_d;
        m_keep_d    = '1;
        m_last_d    = flush_req_q | flush;
        cnt_d       = '0;
        flush_req_d = 1'b0;
      end else begin
        acc_full_d = 1'b1;
      end
    end else if (acc_full_q) begin
      if (out_free) begin
        m_valid_d   = 1'b1;
        m_data_d    = acc_q;
        m_keep_d    = '1;
        m_last_d    = flush_req_q | flush;
        cnt_d       = '0;
        acc_full_d  = 1'b0;
        flush_req_d = 1'b0;
      end
    end else if (flush_req_q && !rd_pend_q) begin
      if (cnt_q == '0) begin
        flush_req_d = 1'b0;
      end else if (out_free) begin
        m_valid_d   = 1'b1;
        m_data_d    = part_data;
        m_keep_d    = part_keep;
        m_last_d    = 1'b1;
        cnt_d       = '0;
        flush_req_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      rd_pend_q   <= 1'b0;
      acc_full_q  <= 1'b0;
      flush_req_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_keep_q    <= '0;
      m_last_q    <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      rd_pend_q   <= r_en;
      acc_full_q  <= acc_full_d;
      flush_req_q <= flush_req_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_keep_q    <= m_keep_d;
      m_last_q    <= m_last_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_last  = m_last_q;

endmodule
